// File: rtl/matrix_mult_avalon_slave_if.sv
// Avalon-MM slave bus bundle for the matrix multiplier peripheral.
interface matrix_mult_avalon_slave_if #(
  parameter int AW = 4
) ();
  logic          chipselect;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [3:0]    byteenable;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          readdatavalid;

  modport slave (
    input  chipselect, address, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );

  modport master (
    output chipselect, address, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );
endinterface

// File: rtl/matrix_mult_avalon_slave.sv
// Avalon-MM matrix multiplier: holds signed N x N operands A and B, computes
// C = A x B with one sequential MAC (N^3 cycles), exposes CTRL/STATUS and irq.
module matrix_mult_avalon_slave #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(3*N*N+2)
) (
  input  logic                           clk,
  input  logic                           rst,
  matrix_mult_avalon_slave_if.slave      avs,
  output logic                           irq
);
  localparam int NN    = N*N;
  localparam int EW    = $clog2(NN);
  localparam int IW    = $clog2(N);
  localparam int ACC_W = 2*DATA_W + $clog2(N);

  localparam logic [AW-1:0] B_BASE    = AW'(NN);
  localparam logic [AW-1:0] C_BASE    = AW'(2*NN);
  localparam logic [AW-1:0] CTRL_ADDR = AW'(3*NN);
  localparam logic [AW-1:0] STAT_ADDR = AW'(3*NN+1);
  localparam logic [IW-1:0] IMAX      = IW'(N-1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t state, state_nxt;

  logic [NN-1:0][DATA_W-1:0] a_mem, b_mem;
  logic [NN-1:0][31:0]       c_mem;

  logic [IW-1:0]           i, j, k;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [2*DATA_W-1:0] prod;
  logic                    done, irq_en, busy;

  logic          wr, rd, start_acc, last_mac;
  logic          in_a, in_b, in_c;
  logic [EW-1:0] idx_a, idx_b, idx_c;
  logic [AW-1:0] off_b, off_c;
  logic [31:0]   be_mask, rd_mux;

  // Bus decode: region select and element offset within each region
  always_comb begin
    wr      = avs.chipselect & avs.write;
    rd      = avs.chipselect & avs.read;
    in_a    = avs.address < B_BASE;
    in_b    = (avs.address >= B_BASE) && (avs.address < C_BASE);
    in_c    = (avs.address >= C_BASE) && (avs.address < CTRL_ADDR);
    off_b   = avs.address - B_BASE;
    off_c   = avs.address - C_BASE;
    idx_a   = EW'(avs.address);
    idx_b   = EW'(off_b);
    idx_c   = EW'(off_c);
    be_mask = {{8{avs.byteenable[3]}}, {8{avs.byteenable[2]}},
               {8{avs.byteenable[1]}}, {8{avs.byteenable[0]}}};
    busy    = (state == CALC);
  end

  // Byte-lane merge; lanes above DATA_W fall off the mask slice
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old);
    return (old & ~be_mask[DATA_W-1:0]) |
           (avs.writedata[DATA_W-1:0] & be_mask[DATA_W-1:0]);
  endfunction

  // MAC datapath: full-precision product and accumulation
  always_comb begin
    prod      = $signed(a_mem[EW'(i*N + k)]) * $signed(b_mem[EW'(k*N + j)]);
    acc_nxt   = acc + ACC_W'(prod);
    start_acc = wr && (avs.address == CTRL_ADDR) && avs.writedata[0] && !busy;
    last_mac  = (i == IMAX) && (j == IMAX) && (k == IMAX);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: start launches CALC, final MAC returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = CALC;
      CALC:    if (last_mac)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Engine counters, operand/result storage and control bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mem  <= '0;
      b_mem  <= '0;
      c_mem  <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      acc    <= '0;
      done   <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (wr && !busy && in_a) a_mem[idx_a] <= merge(a_mem[idx_a]);
      if (wr && !busy && in_b) b_mem[idx_b] <= merge(b_mem[idx_b]);
      if (wr && (avs.address == CTRL_ADDR)) irq_en <= avs.writedata[1];
      // clear first so a same-edge completion below overrides it
      if (wr && (avs.address == STAT_ADDR)) done <= 1'b0;
      if (start_acc) begin
        done <= 1'b0;
        i    <= '0;
        j    <= '0;
        k    <= '0;
        acc  <= '0;
      end else if (busy) begin
        if (k == IMAX) begin
          c_mem[EW'(i*N + j)] <= 32'(acc_nxt);
          acc <= '0;
          k   <= '0;
          if (j == IMAX) begin
            j <= '0;
            i <= i + 1'b1;
            if (i == IMAX) done <= 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          acc <= acc_nxt;
          k   <= k + 1'b1;
        end
      end
    end
  end

  // Read mux: A/B sign-extended, C raw, CTRL/STATUS packed, rest zero
  always_comb begin
    rd_mux = '0;
    if (in_a)      rd_mux = {{(32-DATA_W){a_mem[idx_a][DATA_W-1]}}, a_mem[idx_a]};
    else if (in_b) rd_mux = {{(32-DATA_W){b_mem[idx_b][DATA_W-1]}}, b_mem[idx_b]};
    else if (in_c) rd_mux = c_mem[idx_c];
    else if (avs.address == CTRL_ADDR) rd_mux = {30'b0, irq_en, 1'b0};
    else if (avs.address == STAT_ADDR) rd_mux = {30'b0, done, busy};
  end

  // Fixed one-cycle read latency; readdata holds until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avs.readdata      <= '0;
      avs.readdatavalid <= 1'b0;
    end else begin
      avs.readdatavalid <= rd;
      if (rd) avs.readdata <= rd_mux;
    end
  end

  assign irq = done & irq_en;

  logic unused_bits;
  assign unused_bits = ^{avs.writedata[31:DATA_W], be_mask[31:DATA_W]};
endmodule

// File: doc/matrix_mult_avalon_slave.md
# matrix_mult_avalon_slave

Parametrised Avalon-MM slave that holds two N×N signed operand matrices and computes C = A×B with one sequential multiply-accumulate engine. Software loads A and B through the register map, writes START, and then polls STATUS or waits for the interrupt. It then reads C back. The block sits on the system interconnect as a memory-mapped peripheral. It replaces the fixed 2×2 combinational multiplier wrapper with a registered, handshaked engine.

## Interface
- N, default 2: matrix dimension, legal 2..8.
- DATA_W, default 16: signed element width of A and B, legal 2..16.
- AW, default 4: address width. Must satisfy 2^AW ≥ 3·N·N+2; the top level sets it to that minimum.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- avs_chipselect  in  1  slave select.
- avs_address  in  AW  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_byteenable  in  4  write byte lanes.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- avs_readdatavalid  out  1  one-cycle pulse with readdata.
- irq  out  1  level interrupt = done & irq_en.

## Operation
- Address map, with word address E = i·N + j:
  - A[i][j] at E.
  - B[i][j] at N·N + E.
  - C[i][j] at 2·N·N + E, read-only.
  - CTRL at 3·N·N.
  - STATUS at 3·N·N+1.
- Other addresses: reads return 0; writes are ignored.
- A/B write:
  - Byte lanes whose bit index is below DATA_W update the element when the corresponding byteenable bit is 1.
  - A/B writes are ignored while busy.
  - A/B read-back is sign-extended to 32 bits.
- CTRL:
  - Write bit0 = start, self-clearing. It is ignored while busy.
  - Bit1 = irq_en, a stored bit.
  - A CTRL read returns {30'b0, irq_en, 1'b0}.
- STATUS:
  - Read returns {30'b0, done, busy}.
  - Any write to STATUS clears done.
  - Start also clears done.
- Engine FSM states: IDLE, CALC.
  - IDLE → CALC on an accepted start; i, j, k and the accumulator all reset to 0.
  - In CALC, each cycle computes acc_next = acc + A[i][k]·B[k][j], using full-precision signed arithmetic of width 2·DATA_W + clog2(N).
  - When k = N−1, C[i][j] ← acc_next[31:0]. This is a wrap (truncate), not a saturate; the accumulator clears and k resets. j then advances; when j wraps, i advances.
  - After the write of C[N−1][N−1], the FSM returns to IDLE and sets done.
- C is overwritten element-by-element during CALC. C reads during busy return whatever is stored at that moment.
- Simultaneous events on the same edge:
  - A STATUS write and done being set: the set wins.
  - Start and a STATUS write are impossible, because there is one port.
- Reset (any time, including mid-CALC):
  - FSM → IDLE.
  - busy, done, irq_en, irq, avs_readdatavalid and avs_readdata → 0.
  - All A, B and C elements → 0.

## Timing
- Every access with chipselect and write is accepted in one cycle; there is no waitrequest.
- Read latency is fixed at 1:
  - readdata and readdatavalid are valid on the edge after the read cycle.
  - readdata holds its value until the next read.
  - Back-to-back reads produce back-to-back valids.
- Start written at edge T:
  - busy = 1 from edge T+1.
  - CALC lasts exactly N³ cycles.
  - At edge T+1+N³, busy falls and done rises.
  - For N=2, busy is high for 8 cycles.
- C[i][j] becomes visible N cycles after its first MAC cycle.
- irq rises on the same edge as done (if irq_en = 1). It falls on the edge after done is cleared or irq_en is written 0.
- An A/B write in the same cycle that start is accepted cannot occur, because there is one port. The first MAC uses the values present at edge T.

## Test plan
- Reset, then read every address → all 0, STATUS = 0, irq = 0, readdatavalid exactly one cycle after each read.
- N=2, DATA_W=16: A = [[1,2],[3,4]], B = [[5,6],[7,8]], start, poll → busy for exactly 8 cycles, C = [[19,22],[43,50]], STATUS = 0b10.
- Signed/wrap, N=2: A = [[-32768,-32768],[0,0]], B = [[-32768,0],[-32768,0]] → C[0][0] = 0x80000000 (2³¹ wraps), others 0.
- Protection during busy: write A[0][0] = 9 and a second start while busy → the A write is ignored, busy length is unchanged, and the result matches the original A.
- Byte lanes: write 0xAAAA_1234 to A[0][1] with byteenable = 0b0001, after A[0][1] = 0x5600 → read 0x00005634; byteenable = 0b0100 leaves A[0][1] unchanged.
- IRQ/reset: set irq_en, start, assert rst at cycle 4 of CALC → busy = done = irq = 0 immediately, all C = 0. Rerun to done → irq = 1; STATUS write clears irq on the next edge.
